pong_game_ctrl: RTL and testbench

Game-level sequencer for the Pong datapath. It sits above the ball block and decides when the ball is held at centre, when it moves, and which way it is served. It keeps both players' scores and declares the winner. All decisions are paced by the per-frame tick, so ball motion and game phases change only at frame boundaries.

---
 rtl/pong_game_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game-level sequencer: serve/play/point phases, scores, winner
//
// Purpose: decides when the ball is parked at centre, when it may move and
// which way it is served; keeps both scores and declares the winner. All
// timed phases advance only on frame_tick.
//
// Ports:
//   clk25M     in   pixel clock
//   reset_n    in   asynchronous active-low reset
//   frame_tick in   one-cycle pulse per frame
//   start      in   player button (synchronous level, rising edge used)
//   miss_left  in   ball passed left boundary (pulse)
//   miss_right in   ball passed right boundary (pulse)
//   ball_hold  out  park ball at centre
//   ball_run   out  ball may advance on frame_tick
//   serve_dir  out  next serve direction, 1 = right
//   score_l    out  left score
//   score_r    out  right score
//   game_over  out  high in GAMEOVER
//   winner     out  1 = right player won (valid with game_over)
//   state      out  current state encoding
module pong_game_ctrl #(
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int WIN_SCORE    = 9
) (
   input  logic       clk25M,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       ball_hold,
   output logic       ball_run,
   output logic       serve_dir,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SERVE    = 3'd1,
      ST_PLAY     = 3'd2,
      ST_PAUSE    = 3'd3,
      ST_POINT    = 3'd4,
      ST_GAMEOVER = 3'd5
   } state_t;

   localparam logic [7:0] SERVE_LD = 8'(SERVE_FRAMES);
   localparam logic [7:0] POINT_LD = 8'(POINT_FRAMES);
   localparam logic [3:0] WIN_SC   = 4'(WIN_SCORE);

   state_t     state_q, state_d;
   logic [7:0] frm_cnt_q, frm_cnt_d;
   logic [3:0] score_l_q, score_l_d;
   logic [3:0] score_r_q, score_r_d;
   logic       serve_dir_q, serve_dir_d;
   logic       winner_q, winner_d;
   logic       start_d_q, start_d_d;
   logic       ball_hold_q, ball_hold_d;
   logic       ball_run_q, ball_run_d;
   logic       game_over_q, game_over_d;

   logic       start_rise;
   logic [3:0] score_l_inc;
   logic [3:0] score_r_inc;

   always_comb begin
      state_d     = state_q;
      frm_cnt_d   = frm_cnt_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      start_d_d   = start;
      start_rise  = start & ~start_d_q;
      score_l_inc = score_l_q + 4'd1;
      score_r_inc = score_r_q + 4'd1;

      case (state_q)
         ST_IDLE, ST_GAMEOVER: begin
            if (start_rise) begin
               score_l_d   = 4'd0;
               score_r_d   = 4'd0;
               serve_dir_d = 1'b1;
               frm_cnt_d   = SERVE_LD;
               state_d     = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (frame_tick) begin
               frm_cnt_d = frm_cnt_q - 8'd1;
               if (frm_cnt_q == 8'd1) begin
                  state_d = ST_PLAY;
               end
            end
         end
         ST_PLAY: begin
            // miss_left outranks miss_right, and any miss outranks start
            if (miss_left) begin
               score_r_d   = score_r_inc;
               serve_dir_d = 1'b0;
               if (score_r_inc == WIN_SC) begin
                  winner_d = 1'b1;
                  state_d  = ST_GAMEOVER;
               end else begin
                  frm_cnt_d = POINT_LD;
                  state_d   = ST_POINT;
               end
            end else if (miss_right) begin
               score_l_d   = score_l_inc;
               serve_dir_d = 1'b1;
               if (score_l_inc == WIN_SC) begin
                  winner_d = 1'b0;
                  state_d  = ST_GAMEOVER;
               end else begin
                  frm_cnt_d = POINT_LD;
                  state_d   = ST_POINT;
               end
            end else if (start_rise) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (start_rise) begin
               state_d = ST_PLAY;
            end
         end
         ST_POINT: begin
            if (frame_tick) begin
               if (frm_cnt_q == 8'd1) begin
                  frm_cnt_d = SERVE_LD;
                  state_d   = ST_SERVE;
               end else begin
                  frm_cnt_d = frm_cnt_q - 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // outputs decoded from the next state so they line up with state_q
      ball_hold_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                    (state_d == ST_GAMEOVER);
      ball_run_d  = (state_d == ST_PLAY);
      game_over_d = (state_d == ST_GAMEOVER);
   end

   always_ff @(posedge clk25M or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         frm_cnt_q   <= 8'd0;
         score_l_q   <= 4'd0;
         score_r_q   <= 4'd0;
         serve_dir_q <= 1'b1;
         winner_q    <= 1'b0;
         start_d_q   <= 1'b0;
         ball_hold_q <= 1'b1;
         ball_run_q  <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frm_cnt_q   <= frm_cnt_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         serve_dir_q <= serve_dir_d;
         winner_q    <= winner_d;
         start_d_q   <= start_d_d;
         ball_hold_q <= ball_hold_d;
         ball_run_q  <= ball_run_d;
         game_over_q <= game_over_d;
      end
   end

   assign state     = state_q;
   assign score_l   = score_l_q;
   assign score_r   = score_r_q;
   assign serve_dir = serve_dir_q;
   assign winner    = winner_q;
   assign ball_hold = ball_hold_q;
   assign ball_run  = ball_run_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - scoreboard bench for pong_game_ctrl
module tb_pong_game_ctrl;

   localparam int SF = 3;
   localparam int PF = 2;
   localparam int WS = 2;

   logic       clk25M = 1'b0;
   logic       reset_n;
   logic       frame_tick, start, miss_left, miss_right;
   logic       ball_hold, ball_run, serve_dir, game_over, winner;
   logic [3:0] score_l, score_r;
   logic [2:0] state;

   pong_game_ctrl #(.SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WS)) dut (
      .clk25M     (clk25M),
      .reset_n    (reset_n),
      .frame_tick (frame_tick),
      .start      (start),
      .miss_left  (miss_left),
      .miss_right (miss_right),
      .ball_hold  (ball_hold),
      .ball_run   (ball_run),
      .serve_dir  (serve_dir),
      .score_l    (score_l),
      .score_r    (score_r),
      .game_over  (game_over),
      .winner     (winner),
      .state      (state)
   );

   always #20 clk25M = ~clk25M;

   typedef struct {
      logic [2:0] st;
      logic [3:0] sl;
      logic [3:0] sr;
      logic       dir;
      logic       win;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int   m_st, m_sl, m_sr, m_ticks;
   logic m_dir, m_win, m_prev;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_sl = 0; m_sr = 0; m_ticks = 0;
      m_dir = 1'b1; m_win = 1'b0; m_prev = 1'b0;
   endtask

   task automatic model_step(input logic ft, input logic st, input logic ml, input logic mr);
      logic rise;
      exp_t e;
      rise   = st && !m_prev;
      m_prev = st;
      case (m_st)
         0, 5: if (rise) begin
            m_sl = 0; m_sr = 0; m_dir = 1'b1; m_ticks = 0; m_st = 1;
         end
         1: if (ft) begin
            m_ticks++;
            if (m_ticks == SF) begin m_ticks = 0; m_st = 2; end
         end
         2: begin
            if (ml) begin
               m_sr++; m_dir = 1'b0;
               if (m_sr == WS) begin m_win = 1'b1; m_st = 5; end
               else begin m_ticks = 0; m_st = 4; end
            end else if (mr) begin
               m_sl++; m_dir = 1'b1;
               if (m_sl == WS) begin m_win = 1'b0; m_st = 5; end
               else begin m_ticks = 0; m_st = 4; end
            end else if (rise) begin
               m_st = 3;
            end
         end
         3: if (rise) m_st = 2;
         4: if (ft) begin
            m_ticks++;
            if (m_ticks == PF) begin m_ticks = 0; m_st = 1; end
         end
         default: m_st = 0;
      endcase
      e.st = 3'(m_st); e.sl = 4'(m_sl); e.sr = 4'(m_sr); e.dir = m_dir; e.win = m_win;
      sb.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("score_l", 32'(score_l), 32'(e.sl));
      check_eq("score_r", 32'(score_r), 32'(e.sr));
      check_eq("serve_dir", 32'(serve_dir), 32'(e.dir));
      check_eq("ball_hold", 32'(ball_hold), 32'(e.st == 3'd0 || e.st == 3'd1 || e.st == 3'd5));
      check_eq("ball_run", 32'(ball_run), 32'(e.st == 3'd2));
      check_eq("game_over", 32'(game_over), 32'(e.st == 3'd5));
      if (e.st == 3'd5) check_eq("winner", 32'(winner), 32'(e.win));
   endtask

   task automatic cyc(input logic ft, input logic st, input logic ml, input logic mr);
      @(negedge clk25M);
      frame_tick = ft; start = st; miss_left = ml; miss_right = mr;
      model_step(ft, st, ml, mr);
      @(posedge clk25M);
      #1;
      compare_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic press();
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
      model_reset();
      repeat (3) @(posedge clk25M);
      #1;
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_score_l", 32'(score_l), 32'd0);
      check_eq("rst_score_r", 32'(score_r), 32'd0);
      check_eq("rst_hold", 32'(ball_hold), 32'd1);
      check_eq("rst_run", 32'(ball_run), 32'd0);
      check_eq("rst_dir", 32'(serve_dir), 32'd1);
      check_eq("rst_game_over", 32'(game_over), 32'd0);
      check_eq("rst_winner", 32'(winner), 32'd0);
      @(negedge clk25M);
      reset_n = 1'b1;

      // frame ticks and misses in IDLE change nothing
      ticks(100);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);

      // start, serve: two ticks stay in SERVE, third enters PLAY
      press();
      cyc(1'b0, 1'b1, 1'b0, 1'b0);   // held level: no new edge
      idle(1);
      ticks(2);
      check_eq("serve_after2", 32'(state), 32'd1);
      ticks(1);
      check_eq("play_after3", 32'(state), 32'd2);

      // simultaneous misses: left wins
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      check_eq("sim_miss_sr", 32'(score_r), 32'd1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);   // start and miss ignored in POINT
      idle(1);
      ticks(1);
      check_eq("point_to_serve", 32'(state), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);   // start ignored in SERVE
      idle(1);
      ticks(SF);

      // miss_right point
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      ticks(PF);
      ticks(SF);

      // pause / resume
      press();
      check_eq("paused", 32'(state), 32'd3);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);   // tick and miss ignored in PAUSE
      idle(1);
      press();
      check_eq("resumed", 32'(state), 32'd2);

      // miss beats start; second right miss wins the game for left
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("win_state", 32'(state), 32'd5);
      idle(1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);   // no effect in GAMEOVER
      ticks(2);

      // restart from GAMEOVER, then a plain miss_left
      press();
      ticks(SF);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      ticks(PF);
      ticks(SF);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // asynchronous reset between edges
      #7;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_eq("arst_state", 32'(state), 32'd0);
      check_eq("arst_score_l", 32'(score_l), 32'd0);
      check_eq("arst_score_r", 32'(score_r), 32'd0);
      check_eq("arst_hold", 32'(ball_hold), 32'd1);
      check_eq("arst_dir", 32'(serve_dir), 32'd1);
      @(negedge clk25M);
      reset_n = 1'b1;
      idle(2);
      press();
      ticks(SF);
      check_eq("resume_play", 32'(state), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
